ex_stage_unit: RTL and testbench
================================

Name: ex_stage_unit

Overview:
- Consumer side of the ID/EX pipeline register: the execute stage of the 5-stage RISC-V core.
- Takes the decoded operands and control fields, resolves operand forwarding, and executes single-cycle ALU ops or an iterative multi-cycle MUL.
- Owns the EX/MEM pipeline register and drives stall_o back to the PC, IF/ID and ID/EX registers while a MUL is in flight.

Parameters:
- BITS_PER_CYC, 1: multiplier bits retired per BUSY cycle; legal values are 1, 2, 4, 8. Iterations N = 32/BITS_PER_CYC.

Ports:
- clk_i  in  1  clock; all state updates on the rising edge.
- rst_i  in  1  synchronous, active-high reset.
- RS1data_i  in  32  rs1 value from ID/EX.
- RS2data_i  in  32  rs2 value from ID/EX.
- imm_i  in  32  sign-extended immediate from ID/EX.
- RS1_i  in  5  rs1 index.
- RS2_i  in  5  rs2 index.
- RD_i  in  5  rd index.
- MemtoReg_i  in  1  ID/EX control field.
- ALUCtrl_i  in  3  ID/EX control field; encoding given under Behaviour.
- MemWrite_i  in  1  ID/EX control field.
- ALUSrc_i  in  1  ID/EX control field; 1 selects imm_i as operand B.
- RegWrite_i  in  1  ID/EX control field.
- WB_RD_i  in  5  write-back destination index.
- WB_RegWrite_i  in  1  write-back enable.
- WB_data_i  in  32  write-back value.
- ALUres_o  out  32  EX/MEM ALU result.
- RS2data_o  out  32  EX/MEM store data (forwarded rs2).
- RD_o  out  5  EX/MEM destination index.
- MemtoReg_o  out  1  EX/MEM control field.
- MemWrite_o  out  1  EX/MEM control field.
- RegWrite_o  out  1  EX/MEM control field.
- stall_o  out  1  hold PC, IF/ID and ID/EX this cycle.

Behaviour:
- ALUCtrl encoding:
  - 000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR.
  - 101 SLL, shift amount B[4:0].
  - 110 SRA (arithmetic), shift amount B[4:0].
  - 111 MUL, low 32 bits of the product; sign-agnostic.
  - All other ops wrap modulo 2^32.
- Forwarding, per source (rs1, rs2):
  - Index 0 is never forwarded.
  - First priority: internal EX/MEM, when RegWrite_o=1 and RD_o==RSx.
  - Second priority: WB, when WB_RegWrite_i=1 and WB_RD_i==RSx.
  - Otherwise: the RSxdata_i value.
- Operand A is forwarded rs1. Operand B is imm_i if ALUSrc_i=1, else forwarded rs2. Store data is always forwarded rs2.
- Non-MUL ops: latency 1. EX/MEM loads the result and the ID/EX control and RD fields on the next edge. stall_o=0.
- MUL FSM, states IDLE / BUSY / DONE:
  - IDLE with ALUCtrl_i=111: stall_o=1, combinational from ALUCtrl_i. Latch A, B, RD and the control fields. Counter loads N. EX/MEM loads a bubble (RegWrite/MemWrite/MemtoReg=0, RD=0, data 0). Next state BUSY.
  - BUSY: stall_o=1. Shift-add BITS_PER_CYC bits per cycle; counter decrements. The cycle the counter hits 0 moves to DONE. EX/MEM loads a bubble every BUSY cycle.
  - DONE: stall_o=0. EX/MEM loads the product and the latched control fields. Next state IDLE.
  - Total stall is N+1 cycles; the result is visible on ALUres_o N+2 edges after the MUL enters EX.
  - The ID/EX fields presented in DONE are ignored; ID/EX advances at the DONE edge.
- Back-to-back MUL: the following MUL enters IDLE normally and restarts the FSM.
- Operand capture: operands are captured only at MUL entry. WB activity during BUSY does not alter them.
- Load-use hazards are not handled here; the upstream hazard unit inserts the bubble.
- Reset:
  - State returns to IDLE, counter to 0, stall_o to 0.
  - All EX/MEM outputs go to 0.
  - A MUL in progress is aborted with no write-back.
  - Reset has priority over all other events.

Optional Feature:
- FWD_EN defined: forwarding as described above.
- FWD_EN undefined: operands come directly from RS1data_i/RS2data_i and the WB_* inputs are ignored; the toolchain or hazard unit guarantees the NOP spacing. All other behaviour is identical.

Test Plan:
- ADD x3=x1+x2 with RS1data=5, RS2data=7, no hazards -> next edge ALUres_o=12, RD_o=3, RegWrite_o=1, stall_o never asserted.
- EX/MEM holds RD=1, result 0x10, and WB simultaneously has RD=1, data 0x20; next op is ADD rs1=1, imm=1, ALUSrc=1 -> ALUres_o=0x11 (EX/MEM wins); with FWD_EN undefined -> RS1data_i+1.
- Prior op writes x0 = 0x55, then SUB rs1=0, rs2=0 with stale RS data 0 -> ALUres_o=0 (x0 not forwarded).
- MUL 7 * 0xFFFFFFFD, BITS_PER_CYC=1 -> stall_o high exactly 33 cycles, 33 bubbles in EX/MEM, then ALUres_o=0xFFFFFFEB with RegWrite_o=1.
- rst_i asserted on the 10th BUSY cycle -> next edge: state IDLE, stall_o=0, all outputs 0, no product ever emitted.
- SRA with A=0x80000000, B=4 -> ALUres_o=0xF8000000. SLL with B=0x21 -> shift by 1.

Source files
------------

// File: rtl/ex_stage_unit.sv
// Execute stage of the 5-stage RISC-V core: operand forwarding, single-cycle ALU,
// iterative shift-add MUL and the EX/MEM pipeline register.
// Optional feature: define FWD_EN to enable EX/MEM and WB operand forwarding.
module ex_stage_unit #(
  parameter int unsigned BITS_PER_CYC = 1  // 1, 2, 4 or 8
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [31:0] RS1data_i,
  input  logic [31:0] RS2data_i,
  input  logic [31:0] imm_i,
  input  logic [4:0]  RS1_i,
  input  logic [4:0]  RS2_i,
  input  logic [4:0]  RD_i,
  input  logic        MemtoReg_i,
  input  logic [2:0]  ALUCtrl_i,
  input  logic        MemWrite_i,
  input  logic        ALUSrc_i,
  input  logic        RegWrite_i,
  input  logic [4:0]  WB_RD_i,
  input  logic        WB_RegWrite_i,
  input  logic [31:0] WB_data_i,
  output logic [31:0] ALUres_o,
  output logic [31:0] RS2data_o,
  output logic [4:0]  RD_o,
  output logic        MemtoReg_o,
  output logic        MemWrite_o,
  output logic        RegWrite_o,
  output logic        stall_o
);

  localparam int unsigned N    = 32 / BITS_PER_CYC;
  localparam logic [5:0]  NCnt = 6'(N);

  typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

  state_e      state_q;
  logic [5:0]  cnt_q;
  logic [31:0] acc_q, mcand_q, mplier_q, acc_step;
  logic [31:0] ml_s2_q;
  logic [4:0]  ml_rd_q;
  logic        ml_m2r_q, ml_mw_q, ml_rw_q;

  logic [31:0] ex_res_q, ex_s2_q, ex_res_d, ex_s2_d;
  logic [4:0]  ex_rd_q, ex_rd_d;
  logic        ex_m2r_q, ex_mw_q, ex_rw_q, ex_m2r_d, ex_mw_d, ex_rw_d;

  logic [31:0] rs1_fwd, rs2_fwd, op_a, op_b, alu_res;
  logic        is_mul;

  assign is_mul = (ALUCtrl_i == 3'b111);

`ifdef FWD_EN
  // Operand forwarding: EX/MEM beats WB, x0 never forwarded
  always_comb begin
    rs1_fwd = RS1data_i;
    rs2_fwd = RS2data_i;
    if (RS1_i != 5'd0 && ex_rw_q && ex_rd_q == RS1_i) begin
      rs1_fwd = ex_res_q;
    end else if (RS1_i != 5'd0 && WB_RegWrite_i && WB_RD_i == RS1_i) begin
      rs1_fwd = WB_data_i;
    end
    if (RS2_i != 5'd0 && ex_rw_q && ex_rd_q == RS2_i) begin
      rs2_fwd = ex_res_q;
    end else if (RS2_i != 5'd0 && WB_RegWrite_i && WB_RD_i == RS2_i) begin
      rs2_fwd = WB_data_i;
    end
  end
`else
  // Hazard-free operand supply is guaranteed upstream
  logic unused_fwd;
  assign unused_fwd = ^{RS1_i, RS2_i, WB_RD_i, WB_RegWrite_i, WB_data_i};
  assign rs1_fwd    = RS1data_i;
  assign rs2_fwd    = RS2data_i;
`endif

  assign op_a = rs1_fwd;
  assign op_b = ALUSrc_i ? imm_i : rs2_fwd;

  // Single-cycle ALU; MUL result comes from the iterative datapath instead
  always_comb begin
    alu_res = '0;
    case (ALUCtrl_i)
      3'b000:  alu_res = op_a + op_b;
      3'b001:  alu_res = op_a - op_b;
      3'b010:  alu_res = op_a & op_b;
      3'b011:  alu_res = op_a | op_b;
      3'b100:  alu_res = op_a ^ op_b;
      3'b101:  alu_res = op_a << op_b[4:0];
      3'b110:  alu_res = 32'($signed(op_a) >>> op_b[4:0]);
      default: alu_res = '0;
    endcase
  end

  // One shift-add step retiring BITS_PER_CYC multiplier bits
  always_comb begin
    acc_step = acc_q;
    for (int k = 0; k < BITS_PER_CYC; k++) begin
      if (mplier_q[k]) acc_step = acc_step + (mcand_q << k);
    end
  end

  assign stall_o = (state_q == StBusy) || (state_q == StIdle && is_mul);

  // MUL sequencer: capture at entry, iterate in BUSY, hand off in DONE
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      ml_s2_q  <= '0;
      ml_rd_q  <= '0;
      ml_m2r_q <= 1'b0;
      ml_mw_q  <= 1'b0;
      ml_rw_q  <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (is_mul) begin
            acc_q    <= '0;
            mcand_q  <= op_a;
            mplier_q <= op_b;
            cnt_q    <= NCnt;
            ml_s2_q  <= rs2_fwd;
            ml_rd_q  <= RD_i;
            ml_m2r_q <= MemtoReg_i;
            ml_mw_q  <= MemWrite_i;
            ml_rw_q  <= RegWrite_i;
            state_q  <= StBusy;
          end
        end
        StBusy: begin
          acc_q    <= acc_step;
          mcand_q  <= mcand_q << BITS_PER_CYC;
          mplier_q <= mplier_q >> BITS_PER_CYC;
          cnt_q    <= cnt_q - 6'd1;
          if (cnt_q == 6'd1) state_q <= StDone;
        end
        StDone:  state_q <= StIdle;
        default: state_q <= StIdle;
      endcase
    end
  end

  // EX/MEM next value: ALU result, bubble while MUL runs, product in DONE
  always_comb begin
    ex_res_d = '0;
    ex_s2_d  = '0;
    ex_rd_d  = '0;
    ex_m2r_d = 1'b0;
    ex_mw_d  = 1'b0;
    ex_rw_d  = 1'b0;
    if (state_q == StIdle && !is_mul) begin
      ex_res_d = alu_res;
      ex_s2_d  = rs2_fwd;
      ex_rd_d  = RD_i;
      ex_m2r_d = MemtoReg_i;
      ex_mw_d  = MemWrite_i;
      ex_rw_d  = RegWrite_i;
    end else if (state_q == StDone) begin
      ex_res_d = acc_q;
      ex_s2_d  = ml_s2_q;
      ex_rd_d  = ml_rd_q;
      ex_m2r_d = ml_m2r_q;
      ex_mw_d  = ml_mw_q;
      ex_rw_d  = ml_rw_q;
    end
  end

  // EX/MEM pipeline register
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ex_res_q <= '0;
      ex_s2_q  <= '0;
      ex_rd_q  <= '0;
      ex_m2r_q <= 1'b0;
      ex_mw_q  <= 1'b0;
      ex_rw_q  <= 1'b0;
    end else begin
      ex_res_q <= ex_res_d;
      ex_s2_q  <= ex_s2_d;
      ex_rd_q  <= ex_rd_d;
      ex_m2r_q <= ex_m2r_d;
      ex_mw_q  <= ex_mw_d;
      ex_rw_q  <= ex_rw_d;
    end
  end

  assign ALUres_o   = ex_res_q;
  assign RS2data_o  = ex_s2_q;
  assign RD_o       = ex_rd_q;
  assign MemtoReg_o = ex_m2r_q;
  assign MemWrite_o = ex_mw_q;
  assign RegWrite_o = ex_rw_q;

endmodule

// File: tb/tb_ex_stage_unit.sv
// Self-checking bench for ex_stage_unit: directed cases plus random instruction stream
// checked against an instruction-level reference model.
module tb_ex_stage_unit;

  localparam int unsigned Bpc = 1;
  localparam int unsigned N   = 32 / Bpc;
`ifdef FWD_EN
  localparam bit FwdOn = 1'b1;
`else
  localparam bit FwdOn = 1'b0;
`endif

  localparam logic [2:0] OpAdd = 3'b000, OpSub = 3'b001, OpSll = 3'b101;
  localparam logic [2:0] OpSra = 3'b110, OpMul = 3'b111;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic [31:0] RS1data_i, RS2data_i, imm_i, WB_data_i;
  logic [4:0]  RS1_i, RS2_i, RD_i, WB_RD_i;
  logic        MemtoReg_i, MemWrite_i, ALUSrc_i, RegWrite_i, WB_RegWrite_i;
  logic [2:0]  ALUCtrl_i;
  logic [31:0] ALUres_o, RS2data_o;
  logic [4:0]  RD_o;
  logic        MemtoReg_o, MemWrite_o, RegWrite_o, stall_o;

  int vectors = 0;
  int miscompares = 0;

  // Reference EX/MEM contents
  logic [31:0] m_res, m_s2;
  logic [4:0]  m_rd;
  logic        m_m2r, m_mw, m_rw;

  ex_stage_unit #(.BITS_PER_CYC(Bpc)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .RS1data_i(RS1data_i), .RS2data_i(RS2data_i),
    .imm_i(imm_i), .RS1_i(RS1_i), .RS2_i(RS2_i), .RD_i(RD_i), .MemtoReg_i(MemtoReg_i),
    .ALUCtrl_i(ALUCtrl_i), .MemWrite_i(MemWrite_i), .ALUSrc_i(ALUSrc_i),
    .RegWrite_i(RegWrite_i), .WB_RD_i(WB_RD_i), .WB_RegWrite_i(WB_RegWrite_i),
    .WB_data_i(WB_data_i), .ALUres_o(ALUres_o), .RS2data_o(RS2data_o), .RD_o(RD_o),
    .MemtoReg_o(MemtoReg_o), .MemWrite_o(MemWrite_o), .RegWrite_o(RegWrite_o),
    .stall_o(stall_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %08h expected %08h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_exmem(input string tag, input bit with_store);
    check_val({tag, ".res"}, ALUres_o, m_res);
    if (with_store) check_val({tag, ".st"}, RS2data_o, m_s2);
    check_val({tag, ".rd"}, 32'(RD_o), 32'(m_rd));
    check_val({tag, ".m2r"}, 32'(MemtoReg_o), 32'(m_m2r));
    check_val({tag, ".mw"}, 32'(MemWrite_o), 32'(m_mw));
    check_val({tag, ".rw"}, 32'(RegWrite_o), 32'(m_rw));
  endtask

  function automatic logic [31:0] fwd(input logic [4:0] idx, input logic [31:0] d);
    if (FwdOn && idx != 5'd0 && m_rw && m_rd == idx) return m_res;
    if (FwdOn && idx != 5'd0 && WB_RegWrite_i && WB_RD_i == idx) return WB_data_i;
    return d;
  endfunction

  function automatic logic [31:0] alu(input logic [2:0] op, input logic [31:0] a,
                                      input logic [31:0] b);
    int sh;
    sh = int'(b % 32);
    case (op)
      3'd0: return a + b;
      3'd1: return a - b;
      3'd2: return a & b;
      3'd3: return a | b;
      3'd4: return a ^ b;
      3'd5: return a * (32'd1 << sh);
      3'd6: return 32'($signed(a) >>> sh);
      default: return a * b;
    endcase
  endfunction

  task automatic model_clear();
    m_res = '0; m_s2 = '0; m_rd = '0; m_m2r = 1'b0; m_mw = 1'b0; m_rw = 1'b0;
  endtask

  // Issue one instruction into EX and check everything it produces in EX/MEM
  task automatic run_op(input logic [2:0] op, input logic [4:0] rs1, input logic [4:0] rs2,
                        input logic [4:0] rd, input logic [31:0] d1, input logic [31:0] d2,
                        input logic [31:0] imm, input logic src, input logic rw,
                        input logic mw, input logic m2r, input logic [4:0] wbrd,
                        input logic wbrw, input logic [31:0] wbd);
    logic [31:0] a, s2, b;
    int stalls;
    ALUCtrl_i = op; RS1_i = rs1; RS2_i = rs2; RD_i = rd; RS1data_i = d1; RS2data_i = d2;
    imm_i = imm; ALUSrc_i = src; RegWrite_i = rw; MemWrite_i = mw; MemtoReg_i = m2r;
    WB_RD_i = wbrd; WB_RegWrite_i = wbrw; WB_data_i = wbd;
    a  = fwd(rs1, d1);
    s2 = fwd(rs2, d2);
    b  = src ? imm : s2;
    #1;
    if (op != OpMul) begin
      check_val("stall_alu", 32'(stall_o), 32'd0);
      @(posedge clk_i); #1;
      m_res = alu(op, a, b); m_s2 = s2; m_rd = rd; m_m2r = m2r; m_mw = mw; m_rw = rw;
      check_exmem("alu", 1'b1);
    end else begin
      stalls = 0;
      for (int c = 0; c < N + 1; c++) begin
        if (stall_o) stalls++;
        @(posedge clk_i); #1;
        model_clear();
        check_exmem("bubble", 1'b1);
        // Disturb sources while busy; captured operands must not change
        WB_RD_i = 5'($urandom_range(0, 3)); WB_RegWrite_i = 1'($urandom);
        WB_data_i = $urandom; RS1data_i = $urandom; RS2data_i = $urandom;
        #1;
      end
      check_val("stall_done", 32'(stall_o), 32'd0);
      check_val("stall_cnt", 32'(stalls), 32'(N + 1));
      @(posedge clk_i); #1;
      m_res = alu(OpMul, a, b); m_s2 = s2; m_rd = rd; m_m2r = m2r; m_mw = mw; m_rw = rw;
      check_exmem("mul", 1'b0);
    end
  endtask

  initial begin
    rst_i = 1'b1;
    RS1data_i = '0; RS2data_i = '0; imm_i = '0; RS1_i = '0; RS2_i = '0; RD_i = '0;
    MemtoReg_i = 1'b0; ALUCtrl_i = OpAdd; MemWrite_i = 1'b0; ALUSrc_i = 1'b0;
    RegWrite_i = 1'b0; WB_RD_i = '0; WB_RegWrite_i = 1'b0; WB_data_i = '0;
    model_clear();
    repeat (2) @(posedge clk_i);
    #1;
    check_exmem("reset", 1'b1);
    check_val("reset.stall", 32'(stall_o), 32'd0);
    rst_i = 1'b0;

    // ADD x3 = x1 + x2
    run_op(OpAdd, 5'd1, 5'd2, 5'd3, 32'd5, 32'd7, 32'd0, 1'b0, 1'b1, 1'b0, 1'b0,
           5'd0, 1'b0, 32'd0);
    check_val("add.res", ALUres_o, 32'd12);

    // EX/MEM (x1=0x10) beats WB (x1=0x20)
    run_op(OpAdd, 5'd0, 5'd0, 5'd1, 32'h10, 32'h0, 32'd0, 1'b0, 1'b1, 1'b0, 1'b0,
           5'd0, 1'b0, 32'd0);
    run_op(OpAdd, 5'd1, 5'd0, 5'd2, 32'h100, 32'h0, 32'd1, 1'b1, 1'b1, 1'b0, 1'b0,
           5'd1, 1'b1, 32'h20);
    check_val("fwd_prio", ALUres_o, FwdOn ? 32'h11 : 32'h101);

    // x0 is never forwarded
    run_op(OpAdd, 5'd0, 5'd0, 5'd0, 32'h55, 32'h0, 32'd0, 1'b0, 1'b1, 1'b0, 1'b0,
           5'd0, 1'b0, 32'd0);
    run_op(OpSub, 5'd0, 5'd0, 5'd4, 32'h0, 32'h0, 32'd0, 1'b0, 1'b1, 1'b0, 1'b0,
           5'd0, 1'b1, 32'h77);
    check_val("x0", ALUres_o, 32'd0);

    // MUL 7 * -3
    run_op(OpMul, 5'd5, 5'd6, 5'd7, 32'd7, 32'hFFFF_FFFD, 32'd0, 1'b0, 1'b1, 1'b0, 1'b0,
           5'd0, 1'b0, 32'd0);
    check_val("mul7", ALUres_o, 32'hFFFF_FFEB);

    // Shifts
    run_op(OpSra, 5'd8, 5'd0, 5'd9, 32'h8000_0000, 32'd0, 32'd4, 1'b1, 1'b1, 1'b0, 1'b0,
           5'd0, 1'b0, 32'd0);
    check_val("sra", ALUres_o, 32'hF800_0000);
    run_op(OpSll, 5'd8, 5'd0, 5'd9, 32'd3, 32'd0, 32'h21, 1'b1, 1'b1, 1'b0, 1'b0,
           5'd0, 1'b0, 32'd0);
    check_val("sll", ALUres_o, 32'd6);

    // Reset on the 10th BUSY cycle aborts the MUL
    ALUCtrl_i = OpMul; RS1_i = 5'd10; RS2_i = 5'd11; RD_i = 5'd12; RS1data_i = 32'd9;
    RS2data_i = 32'd9; ALUSrc_i = 1'b0; RegWrite_i = 1'b1; WB_RegWrite_i = 1'b0;
    repeat (10) @(posedge clk_i);
    #1;
    check_val("busy.stall", 32'(stall_o), 32'd1);
    rst_i = 1'b1; ALUCtrl_i = OpAdd; RegWrite_i = 1'b0;
    @(posedge clk_i); #1;
    rst_i = 1'b0;
    model_clear();
    check_exmem("abort", 1'b1);
    check_val("abort.stall", 32'(stall_o), 32'd0);
    for (int i = 0; i < N + 4; i++) begin
      run_op(OpAdd, 5'd0, 5'd0, 5'd0, 32'd0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0,
             5'd0, 1'b0, 32'd0);
    end

    // Random instruction stream
    for (int i = 0; i < 150; i++) begin
      run_op(3'($urandom_range(0, 7)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
             5'($urandom_range(0, 3)), $urandom, $urandom,
             ($urandom_range(0, 1) != 0) ? 32'($urandom_range(0, 40)) : $urandom,
             1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
             5'($urandom_range(0, 3)), 1'($urandom), $urandom);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
